// File: rtl/clint_rd_arbiter.sv
// clint_rd_arbiter: two-master to one-slave AXI4-Lite read arbiter.
// Serialises IFU (m0) and LSU (m1) reads onto one read slave.
//
// Ports:
//   i_clock, i_reset  : clock, synchronous active-high reset
//   i_m0_* / o_m0_*   : master 0 (IFU) ar and r channels
//   i_m1_* / o_m1_*   : master 1 (LSU) ar and r channels
//   o_s_* / i_s_*     : shared slave ar and r channels
// Parameters:
//   ADDR_W, DATA_W    : ar address and r data widths
//   FIXED_PRIO        : 0 = round-robin, 1 = m1 wins every tie

module clint_rd_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_m0_araddr,
  input  logic              i_m0_arvalid,
  output logic              o_m0_arready,
  output logic [DATA_W-1:0] o_m0_rdata,
  output logic [1:0]        o_m0_rresp,
  output logic              o_m0_rvalid,
  input  logic              i_m0_rready,
  input  logic [ADDR_W-1:0] i_m1_araddr,
  input  logic              i_m1_arvalid,
  output logic              o_m1_arready,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic [1:0]        o_m1_rresp,
  output logic              o_m1_rvalid,
  input  logic              i_m1_rready,
  output logic [ADDR_W-1:0] o_s_araddr,
  output logic              o_s_arvalid,
  input  logic              i_s_arready,
  input  logic [DATA_W-1:0] i_s_rdata,
  input  logic [1:0]        i_s_rresp,
  input  logic              i_s_rvalid,
  output logic              o_s_rready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   grant;
  logic   grant_nxt;
  logic   last_grant;
  logic   last_nxt;
  logic   pick;
  logic   ar_hs;
  logic   r_hs;

  // Tie-break: round-robin favours whoever was not served last.
  always_comb begin
    pick = i_m1_arvalid;
    if (i_m0_arvalid && i_m1_arvalid) begin
      if (FIXED_PRIO != 0) pick = 1'b1;
      else                 pick = ~last_grant;
    end
  end

  assign ar_hs = (state == ADDR)
               && i_s_arready && o_s_arvalid;
  assign r_hs  = (state == DATA)
               && i_s_rvalid && o_s_rready;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last_grant;
    unique case (state)
      IDLE: begin
        if (i_m0_arvalid || i_m1_arvalid) begin
          state_nxt = ADDR;
          grant_nxt = pick;
        end
      end
      ADDR: begin
        if (ar_hs) state_nxt = DATA;
      end
      DATA: begin
        if (r_hs) begin
          state_nxt = IDLE;
          last_nxt  = grant;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_s_araddr   = '0;
    o_s_arvalid  = 1'b0;
    o_m0_arready = 1'b0;
    o_m1_arready = 1'b0;
    o_s_rready   = 1'b0;
    o_m0_rvalid  = 1'b0;
    o_m0_rdata   = '0;
    o_m0_rresp   = 2'b00;
    o_m1_rvalid  = 1'b0;
    o_m1_rdata   = '0;
    o_m1_rresp   = 2'b00;
    if (state == ADDR) begin
      if (grant) begin
        o_s_araddr   = i_m1_araddr;
        o_s_arvalid  = i_m1_arvalid;
        o_m1_arready = i_s_arready;
      end else begin
        o_s_araddr   = i_m0_araddr;
        o_s_arvalid  = i_m0_arvalid;
        o_m0_arready = i_s_arready;
      end
    end
    if (state == DATA) begin
      if (grant) begin
        o_s_rready  = i_m1_rready;
        o_m1_rvalid = i_s_rvalid;
        o_m1_rdata  = i_s_rdata;
        o_m1_rresp  = i_s_rresp;
      end else begin
        o_s_rready  = i_m0_rready;
        o_m0_rvalid = i_s_rvalid;
        o_m0_rdata  = i_s_rdata;
        o_m0_rresp  = i_s_rresp;
      end
    end
  end

endmodule

// File: tb/tb_clint_rd_arbiter.sv
// tb_clint_rd_arbiter: bench for the two-master read arbiter.
// Instance 0 is round-robin, instance 1 is fixed priority.

module tb_clint_rd_arbiter;

  localparam logic [31:0] A0 = 32'ha000_0048;
  localparam logic [31:0] A1 = 32'ha000_0050;

  logic clk;
  logic rst;

  logic [31:0] m_araddr  [2][2];
  logic        m_arvalid [2][2];
  logic        m_arready [2][2];
  logic [31:0] m_rdata   [2][2];
  logic [1:0]  m_rresp   [2][2];
  logic        m_rvalid  [2][2];
  logic        m_rready  [2][2];
  logic [31:0] s_araddr  [2];
  logic        s_arvalid [2];
  logic        s_arready [2];
  logic [31:0] s_rdata   [2];
  logic [1:0]  s_rresp   [2];
  logic        s_rvalid  [2];
  logic        s_rready  [2];

  bit          arready_en;
  bit          rvalid_en;
  bit          rready_en [2];
  int          tgt   [2][2];
  int          done  [2][2];
  bit          outst [2][2];
  bit          s_pend [2];
  logic [31:0] s_addr [2];

  bit mb_busy  [2];
  bit mb_adone [2];
  bit mb_own   [2];
  bit mb_last  [2];
  int glog0[$];
  int glog1[$];
  logic [31:0] obs0[$];
  logic [31:0] obs1[$];

  bit cmp_on;
  int checks;
  int errs;

  function automatic logic [31:0] sdata(
    input logic [31:0] a);
    return (a == A0) ? 32'h0000_1234 : ~a;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gi
    clint_rd_arbiter #(
      .ADDR_W(32), .DATA_W(32), .FIXED_PRIO(g)
    ) dut (
      .i_clock     (clk),
      .i_reset     (rst),
      .i_m0_araddr (m_araddr[g][0]),
      .i_m0_arvalid(m_arvalid[g][0]),
      .o_m0_arready(m_arready[g][0]),
      .o_m0_rdata  (m_rdata[g][0]),
      .o_m0_rresp  (m_rresp[g][0]),
      .o_m0_rvalid (m_rvalid[g][0]),
      .i_m0_rready (m_rready[g][0]),
      .i_m1_araddr (m_araddr[g][1]),
      .i_m1_arvalid(m_arvalid[g][1]),
      .o_m1_arready(m_arready[g][1]),
      .o_m1_rdata  (m_rdata[g][1]),
      .o_m1_rresp  (m_rresp[g][1]),
      .o_m1_rvalid (m_rvalid[g][1]),
      .i_m1_rready (m_rready[g][1]),
      .o_s_araddr  (s_araddr[g]),
      .o_s_arvalid (s_arvalid[g]),
      .i_s_arready (s_arready[g]),
      .i_s_rdata   (s_rdata[g]),
      .i_s_rresp   (s_rresp[g]),
      .i_s_rvalid  (s_rvalid[g]),
      .o_s_rready  (s_rready[g])
    );

    // Slave agent: answers one cycle after the ar handshake.
    assign s_arready[g] = arready_en;
    assign s_rvalid[g]  = s_pend[g] && rvalid_en;
    assign s_rdata[g]   = sdata(s_addr[g]);
    assign s_rresp[g]   = s_addr[g][4] ? 2'b10 : 2'b00;

    always @(posedge clk) begin
      if (rst) begin
        s_pend[g] <= 1'b0;
        s_addr[g] <= '0;
      end else if (s_arvalid[g] && s_arready[g]) begin
        s_pend[g] <= 1'b1;
        s_addr[g] <= s_araddr[g];
      end else if (s_rvalid[g] && s_rready[g]) begin
        s_pend[g] <= 1'b0;
      end
      if (!rst && s_arvalid[g] && s_arready[g]) begin
        if (g == 0) obs0.push_back(s_araddr[g]);
        else        obs1.push_back(s_araddr[g]);
      end
    end

    // Master agents: hold arvalid until accepted.
    for (genvar m = 0; m < 2; m++) begin : gm
      assign m_araddr[g][m]  = (m == 0) ? A0 : A1;
      assign m_arvalid[g][m] = (done[g][m] < tgt[g][m])
                             && !outst[g][m];
      assign m_rready[g][m]  = rready_en[m];

      initial done[g][m] = 0;
      always @(posedge clk) begin
        if (rst) begin
          outst[g][m] <= 1'b0;
        end else begin
          if (m_arvalid[g][m] && m_arready[g][m])
            outst[g][m] <= 1'b1;
          if (m_rvalid[g][m] && m_rready[g][m]) begin
            outst[g][m] <= 1'b0;
            done[g][m]  <= done[g][m] + 1;
          end
        end
      end
    end

    // Transaction-level model: one read in flight,
    // phase = waiting for address accept / for data.
    always @(posedge clk) begin
      bit p;
      bit any;
      any = m_arvalid[g][0] || m_arvalid[g][1];
      if (m_arvalid[g][0] && m_arvalid[g][1])
        p = (g == 1) ? 1'b1 : !mb_last[g];
      else
        p = m_arvalid[g][1];
      if (rst) begin
        mb_busy[g]  <= 1'b0;
        mb_adone[g] <= 1'b0;
        mb_last[g]  <= 1'b1;
      end else if (!mb_busy[g]) begin
        if (any) begin
          mb_busy[g]  <= 1'b1;
          mb_adone[g] <= 1'b0;
          mb_own[g]   <= p;
          if (g == 0) glog0.push_back(int'(p));
          else        glog1.push_back(int'(p));
        end
      end else if (!mb_adone[g]) begin
        if (m_arvalid[g][mb_own[g]] && arready_en)
          mb_adone[g] <= 1'b1;
      end else if (m_rready[g][mb_own[g]]
                   && s_rvalid[g]) begin
        mb_busy[g] <= 1'b0;
        mb_last[g] <= mb_own[g];
      end
    end

    always @(negedge clk) begin
      bit ia;
      bit idt;
      bit o;
      string k;
      if (cmp_on) begin
        ia  = mb_busy[g] && !mb_adone[g];
        idt = mb_busy[g] && mb_adone[g];
        o   = mb_own[g];
        k   = $sformatf("k%0d", g);
        chk({k, " s_arvalid"}, 32'(s_arvalid[g]),
            32'(ia && m_arvalid[g][o]));
        chk({k, " s_araddr"}, s_araddr[g],
            ia ? m_araddr[g][o] : 32'h0);
        chk({k, " s_rready"}, 32'(s_rready[g]),
            32'(idt && m_rready[g][o]));
        for (int m = 0; m < 2; m++) begin
          chk($sformatf("%s m%0d_arready", k, m),
              32'(m_arready[g][m]),
              32'(ia && o == m && arready_en));
          chk($sformatf("%s m%0d_rvalid", k, m),
              32'(m_rvalid[g][m]),
              32'(idt && o == m && s_rvalid[g]));
          if (idt) begin
            chk($sformatf("%s m%0d_rdata", k, m),
                m_rdata[g][m],
                (o == m) ? s_rdata[g] : 32'h0);
            chk($sformatf("%s m%0d_rresp", k, m),
                32'(m_rresp[g][m]),
                (o == m) ? 32'(s_rresp[g]) : 32'h0);
          end
        end
      end
    end
  end

  task automatic issue(input int m, input int n);
    for (int k = 0; k < 2; k++)
      tgt[k][m] = done[k][m] + n;
  endtask

  task automatic cancel_all();
    for (int k = 0; k < 2; k++)
      for (int m = 0; m < 2; m++)
        tgt[k][m] = done[k][m];
  endtask

  function automatic bit all_idle();
    bit r;
    r = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (s_pend[k]) r = 1'b0;
      for (int m = 0; m < 2; m++)
        if (done[k][m] < tgt[k][m]) r = 1'b0;
    end
    return r;
  endfunction

  task automatic wait_idle(input string nm,
                           input int budget);
    int n;
    n = 0;
    while (!all_idle() && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " idle timeout"}, 32'(all_idle()), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_pend(input string nm,
                           input int budget);
    int n;
    n = 0;
    while (!(s_pend[0] && s_pend[1]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " data timeout"},
        32'(s_pend[0] && s_pend[1]), 32'd1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cancel_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int exp_rr[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
  int exp_fp[8] = '{1, 1, 1, 1, 0, 0, 0, 0};

  initial begin
    int first;
    int first1;
    bit seen1;
    bit idle_ok;
    logic [31:0] rd;
    logic [1:0]  rr;
    int b0, b1, o0, o1;
    checks = 0;
    errs = 0;
    cmp_on = 1'b0;
    rst = 1'b1;
    arready_en = 1'b0;
    rvalid_en = 1'b0;
    rready_en[0] = 1'b0;
    rready_en[1] = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int m = 0; m < 2; m++)
        tgt[k][m] = 0;
    repeat (2) @(negedge clk);
    cmp_on = 1'b1;
    rst = 1'b0;

    // Reset state
    for (int k = 0; k < 2; k++) begin
      chk("rst s_arvalid", 32'(s_arvalid[k]), 0);
      chk("rst s_araddr", s_araddr[k], 0);
      chk("rst s_rready", 32'(s_rready[k]), 0);
      for (int m = 0; m < 2; m++) begin
        chk("rst arready", 32'(m_arready[k][m]), 0);
        chk("rst rvalid", 32'(m_rvalid[k][m]), 0);
      end
    end

    // Single m0 read, CLINT-like slave
    arready_en = 1'b1;
    rvalid_en = 1'b1;
    rready_en[0] = 1'b1;
    rready_en[1] = 1'b1;
    issue(0, 1);
    first = -1;
    seen1 = 1'b0;
    rd = '0;
    rr = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (m_rvalid[0][0] && first < 0) begin
        first = c;
        rd = m_rdata[0][0];
        rr = m_rresp[0][0];
      end
      if (m_rvalid[0][1]) seen1 = 1'b1;
    end
    chk("single rvalid cycle", first, 2);
    chk("single rdata", rd, 32'h0000_1234);
    chk("single rresp", 32'(rr), 0);
    chk("single m1 rvalid", 32'(seen1), 0);
    wait_idle("single", 50);

    // Simultaneous requests, four each
    pulse_reset();
    b0 = glog0.size();
    b1 = glog1.size();
    o0 = obs0.size();
    o1 = obs1.size();
    issue(0, 4);
    issue(1, 4);
    wait_idle("tie", 300);
    chk("rr grant count", glog0.size() - b0, 8);
    chk("fp grant count", glog1.size() - b1, 8);
    chk("rr addr count", obs0.size() - o0, 8);
    chk("fp addr count", obs1.size() - o1, 8);
    if (glog0.size() - b0 >= 8 && obs0.size() - o0 >= 8
        && glog1.size() - b1 >= 8
        && obs1.size() - o1 >= 8) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("rr grant %0d", i),
            glog0[b0 + i], exp_rr[i]);
        chk($sformatf("rr addr %0d", i), obs0[o0 + i],
            exp_rr[i] != 0 ? A1 : A0);
        chk($sformatf("fp grant %0d", i),
            glog1[b1 + i], exp_fp[i]);
        chk($sformatf("fp addr %0d", i), obs1[o1 + i],
            exp_fp[i] != 0 ? A1 : A0);
      end
    end

    // m1 stalls its r channel for 5 cycles
    rready_en[1] = 1'b0;
    issue(1, 1);
    wait_pend("stall", 20);
    issue(0, 1);
    repeat (5) begin
      for (int k = 0; k < 2; k++) begin
        chk("stall s_rready", 32'(s_rready[k]), 0);
        chk("stall m1 rvalid", 32'(m_rvalid[k][1]), 1);
        chk("stall s_arvalid", 32'(s_arvalid[k]), 0);
      end
      @(negedge clk);
    end
    rready_en[1] = 1'b1;
    first = -1;
    first1 = -1;
    idle_ok = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1)
        idle_ok = !s_arvalid[0] && !m_rvalid[0][1]
                  && !s_arvalid[1];
      if (s_arvalid[0] && first < 0) begin
        first = c;
        rd = s_araddr[0];
      end
      if (s_arvalid[1] && first1 < 0) first1 = c;
    end
    chk("stall idle bubble", 32'(idle_ok), 1);
    chk("stall m0 grant rr", first, 2);
    chk("stall m0 grant fp", first1, 2);
    chk("stall m0 addr", rd, A0);
    wait_idle("stall", 50);

    // Reset in the middle of a data phase
    rready_en[0] = 1'b0;
    issue(0, 1);
    wait_pend("mid rst", 20);
    for (int k = 0; k < 2; k++)
      chk("pre-rst rvalid", 32'(m_rvalid[k][0]), 1);
    rst = 1'b1;
    cancel_all();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("mid rst m0 rvalid", 32'(m_rvalid[k][0]), 0);
      chk("mid rst m1 rvalid", 32'(m_rvalid[k][1]), 0);
      chk("mid rst s_rready", 32'(s_rready[k]), 0);
    end
    rst = 1'b0;
    rready_en[0] = 1'b1;
    o0 = obs0.size();
    o1 = obs1.size();
    issue(0, 1);
    issue(1, 1);
    wait_idle("post rst", 100);
    chk("post rst rr count", obs0.size() - o0, 2);
    chk("post rst fp count", obs1.size() - o1, 2);
    if (obs0.size() > o0)
      chk("post rst rr first", obs0[o0], A0);
    if (obs1.size() > o1)
      chk("post rst fp first", obs1[o1], A1);

    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
